// File: rtl/pht_scheduler_pkg.sv
// Shared types and default parameters for the PHT scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: scheduler state enum, resolve-queue entry struct, default
// parameter values and a small entry constructor.
package pht_sched_pkg;

    localparam int W_IND_DEF      = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    // The entry index width follows W_IND_DEF, so the scheduler's W_IND
    // parameter is expected to stay at this package default.
    typedef struct packed {
        logic [W_IND_DEF-1:0] index;
        logic                 taken;
    } res_entry_t;

    function automatic res_entry_t mk_entry(input logic [W_IND_DEF-1:0] idx,
                                            input logic                 taken);
        res_entry_t e;
        e.index = idx;
        e.taken = taken;
        return e;
    endfunction

endpackage

// File: rtl/pht_scheduler_if.sv
// Bundle of fetch, execute, flush and PHT-command signals for the scheduler.
// Latency: n/a (wiring only).
// Backpressure: res_ready gates resolve pushes; pred_gnt acknowledges predicts.
//
// master: the surrounding pipeline and PHT (drives requests and PHT outputs).
// slave : pht_scheduler (drives grants, queue status and PHT commands).
interface pht_scheduler_if
    import pht_sched_pkg::*;
#(
    parameter int W_IND = W_IND_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic                     en;
    logic                     pred_req;
    logic [W_IND-1:0]         pred_index;
    logic                     pred_gnt;
    logic                     pred_rsp_valid;
    logic                     pred_rsp_taken;
    logic                     res_valid;
    logic [W_IND-1:0]         res_index;
    logic                     res_taken;
    logic                     res_ready;
    logic                     flush;
    logic                     flush_done;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     pht_en;
    logic                     pht_predict;
    logic                     pht_resolve;
    logic                     pht_incr;
    logic                     pht_decr;
    logic [W_IND-1:0]         pht_index;
    logic                     pht_pred_valid;
    logic                     pht_final_pred;

    modport master (
        output en, pred_req, pred_index, res_valid, res_index, res_taken, flush,
               pht_pred_valid, pht_final_pred,
        input  pred_gnt, pred_rsp_valid, pred_rsp_taken, res_ready, flush_done,
               q_count, pht_en, pht_predict, pht_resolve, pht_incr, pht_decr,
               pht_index
    );

    modport slave (
        input  en, pred_req, pred_index, res_valid, res_index, res_taken, flush,
               pht_pred_valid, pht_final_pred,
        output pred_gnt, pred_rsp_valid, pred_rsp_taken, res_ready, flush_done,
               q_count, pht_en, pht_predict, pht_resolve, pht_incr, pht_decr,
               pht_index
    );

endinterface

// File: rtl/pht_scheduler_resolve_queue.sv
// In-order resolve queue with per-slot valid/index taps for hazard compare.
// Latency: a pushed entry becomes visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
//
// Ports: clk, rst (async active-high); push_i/push_dat_i; pop_i; head_o;
// full_o, empty_o, count_o; vld_o / idx_flat_o per physical slot.
module resolve_queue
    import pht_sched_pkg::*;
#(
    parameter int W_IND = W_IND_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  res_entry_t                 push_dat_i,
    input  logic                       pop_i,
    output res_entry_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           vld_o,
    output logic [DEPTH*W_IND-1:0]     idx_flat_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    res_entry_t        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        vld_o      = '0;
        idx_flat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_o[i] = {1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q;
            idx_flat_o[i*W_IND +: W_IND] = mem_q[i].index;
        end
    end

endmodule

// File: rtl/pht_scheduler.sv
// Single-port PHT sequencer: arbitrates predicts vs queued resolves, drains on flush.
// Latency: predict/resolve issue combinationally in the request cycle; responses next cycle.
// Backpressure: res_ready drops when the queue is full; pred_gnt withheld on hazard/starve/drain.
//
// Ports: clk, rst (async active-high); bus (pht_scheduler_if.slave) carrying
// fetch predicts, execute resolves, flush handshake, queue count and PHT commands.
module pht_scheduler
    import pht_sched_pkg::*;
#(
    parameter int W_IND      = W_IND_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pht_scheduler_if.slave   bus
);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    sched_state_e              state_q, state_d;
    logic [SW-1:0]             starve_q, starve_d;

    res_entry_t                q_head;
    logic                      q_full, q_empty, q_push;
    logic [$clog2(DEPTH):0]    q_count;
    logic [DEPTH-1:0]          q_vld;
    logic [DEPTH*W_IND-1:0]    q_idx_flat;

    logic                      active, hazard, do_pred, do_res, flush_done;

    assign bus.res_ready = !q_full && !rst;
    assign q_push        = bus.res_valid && bus.res_ready;

    resolve_queue #(
        .W_IND (W_IND),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (q_push),
        .push_dat_i (mk_entry(bus.res_index, bus.res_taken)),
        .pop_i      (do_res),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count),
        .vld_o      (q_vld),
        .idx_flat_o (q_idx_flat)
    );

    // Compares against registered queue contents only, so an entry pushed
    // this cycle cannot block the predict until the following cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_idx_flat[i*W_IND +: W_IND] == bus.pred_index))
                hazard = 1'b1;
        end
        hazard = hazard && bus.pred_req;
    end

    // rst gates issue directly so commands drop the instant reset asserts.
    assign active = bus.en && !rst;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        do_pred    = 1'b0;
        do_res     = 1'b0;
        flush_done = 1'b0;

        case (state_q)
            RUN: begin
                if (active) begin
                    if (!q_empty && (q_full || (starve_q == SW'(STARVE_MAX)) || hazard))
                        do_res = 1'b1;
                    else if (bus.pred_req)
                        do_pred = 1'b1;
                    else if (!q_empty)
                        do_res = 1'b1;
                end
                if (bus.flush) state_d = DRAIN;
            end
            DRAIN: begin
                do_res = active && !q_empty;
                if (q_empty) begin
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (active) begin
            if (q_empty || do_res)
                starve_d = '0;
            else if (do_pred && (starve_q != SW'(STARVE_MAX)))
                starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign bus.pred_gnt       = do_pred;
    assign bus.flush_done     = flush_done;
    assign bus.q_count        = q_count;
    assign bus.pht_en         = do_pred || do_res;
    assign bus.pht_predict    = do_pred;
    assign bus.pht_resolve    = do_res;
    assign bus.pht_incr       = do_res && q_head.taken;
    assign bus.pht_decr       = do_res && !q_head.taken;
    assign bus.pht_index      = do_pred ? bus.pred_index :
                                do_res  ? q_head.index   : '0;
    assign bus.pred_rsp_valid = bus.pht_pred_valid;
    assign bus.pred_rsp_taken = bus.pht_final_pred;

endmodule

// File: doc/pht_scheduler.md
# pht_scheduler

Sequencing controller for the single-ported pattern history table (2-bit saturating counters, one predict or one resolve per enabled cycle). Arbitrates between fetch-side predict requests and execute-side resolve updates, buffers resolves in a small in-order queue, and blocks a predict that reads an index with a still-queued update. Also provides a flush sequence that drains all pending updates before the front end restarts. Sits between fetch/execute and the PHT instance, driving its en/predict/resolve/incr/decr/index inputs.

## Interface
- W_IND, 4: PHT index width; table has 2**W_IND entries.
- DEPTH, 4: resolve queue depth; power of two, ≥ 2.
- STARVE_MAX, 3: consecutive predict grants allowed while the queue is non-empty, before a resolve is forced.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. When 0, no PHT command is issued, but the queue still accepts pushes.
- pred_req  in  1  fetch predict request.
- pred_index  in  W_IND  predict index.
- pred_gnt  out  1  predict issued to the PHT this cycle (combinational).
- pred_rsp_valid  out  1  prediction valid; driven from pht_pred_valid.
- pred_rsp_taken  out  1  predicted direction; driven from pht_final_pred.
- res_valid  in  1  resolve push request.
- res_index  in  W_IND  resolved branch index.
- res_taken  in  1  actual outcome.
- res_ready  out  1  queue can accept a push this cycle.
- flush  in  1  single-cycle pulse that starts a drain.
- flush_done  out  1  single-cycle pulse when the drain completes.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.
- pht_en, pht_predict, pht_resolve, pht_incr, pht_decr  out  1 each  PHT command lines.
- pht_index  out  W_IND  PHT index.
- pht_pred_valid, pht_final_pred  in  1 each  PHT prediction outputs.

## Operation
- States: RUN and DRAIN. Reset enters RUN.
- RUN arbitration, evaluated each cycle with en=1. Exactly one command per cycle; rules in priority order:
  1. The queue is non-empty and any of the following holds:
     - the queue is full;
     - starve == STARVE_MAX;
     - hazard is set.
     Action: resolve the queue head.
  2. Otherwise, if pred_req: issue a predict.
  3. Otherwise, if the queue is non-empty: resolve the head.
  4. Otherwise: idle, pht_en=0.
- hazard = pred_req and pred_index equals the index of any valid queue entry. An entry pushed in the current cycle is not visible to hazard until the next cycle.
- Predict command: pht_en=1, pht_predict=1, pht_index=pred_index, pred_gnt=1.
- Resolve command: pht_en=1, pht_resolve=1, pht_index=head index, pht_incr=head taken, pht_decr=!head taken. The head is popped in the same cycle.
- starve counter:
  - Increments on a predict grant while the queue is non-empty.
  - Clears on any resolve issue or whenever the queue is empty.
  - Saturates at STARVE_MAX.
- DRAIN state:
  - Entered on flush from RUN.
  - pred_gnt is held at 0 and a resolve is issued every cycle with en=1.
  - When the queue is empty at a clock edge, flush_done pulses for one cycle and the state returns to RUN.
  - A flush while already in DRAIN is ignored.
- Queue behaviour:
  - res_ready = !full and !rst.
  - A push is accepted when res_valid && res_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - No cut-through: an entry pushed into an empty queue can issue no earlier than the next cycle.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - pred_gnt=0, flush_done=0, q_count=0, all pht_* command lines=0.
  - Queue empty, starve=0, state RUN, res_ready=0 while rst is high.
- Predict latency:
  - pred_gnt is asserted in cycle N.
  - The PHT registers the prediction at the end of N.
  - pred_rsp_valid/pred_rsp_taken are valid in cycle N+1.
- Resolve latency:
  - A push at cycle N can issue no earlier than N+1.
  - The counter update is visible to a predict issued one cycle after the resolve.
- Flush on an empty queue: flush_done in cycle N+1.
- Reset mid-operation:
  - The queue is discarded.
  - No further commands are issued.
  - The outputs return to their reset values asynchronously.
- en=0: all command outputs are 0, with no pops and no starve change.

## Structure
- Package pht_sched_pkg:
  - state enum {RUN, DRAIN};
  - queue entry struct {index, taken};
  - default parameter constants.
- Sub-module resolve_queue:
  - synchronous FIFO with flat valid/index vectors exposed for hazard compare;
  - push, pop, full, empty and count.
- Arbitration, starve counter and FSM live in pht_scheduler.

## Test plan
- Predict alone: reset, pred_req idx 5 with the queue empty → pred_gnt the same cycle, pht_predict=1, pht_index=5; pred_rsp_valid the next cycle with taken=0 (counters reset to 00).
- Resolve ordering: push idx 3 taken ×2, then predict idx 3 → hazard forces both resolves first; the predict then returns taken=1 (counter 10).
- Starvation: queue holds 1 entry, pred_req held high on unrelated indices → 3 grants, then a forced resolve, starve clears, and predicts resume.
- Full queue: 4 pushes with continuous pred_req → res_ready=0; the resolve wins the next cycle and res_ready returns to 1 the cycle after the pop.
- Flush: 3 entries queued, flush pulse → pred_gnt=0 for 3 cycles, 3 resolves in order, flush_done one cycle after empty, back in RUN.
- Reset mid-drain: assert rst with 2 entries in DRAIN → q_count=0 and commands 0 immediately; after release, no stale resolve is issued.
